// File: rtl/bundle_pkg.sv
// Shared widths, beat-counter sizing and FSM state type for the bundle deserializer.
// Used by bundle_deser and beat_parity_chk.
package bundle_pkg;

  localparam int unsigned BUNDLE_W = 144;
  localparam int unsigned BEAT_W   = 16;
  localparam int unsigned BEATS    = BUNDLE_W / BEAT_W;

  // Counter width for a given beat count; a single-beat bundle still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/beat_parity_chk.sv
// Even-parity check of one link beat against its sideband parity bit.
// Instantiated by bundle_deser only when BUNDLE_PARITY_EN is defined.
module beat_parity_chk #(
  parameter int unsigned BEAT_W = bundle_pkg::BEAT_W
) (
  input  logic [BEAT_W-1:0] beat,
  input  logic              par,
  output logic              par_err_c
);

  // par carries the XOR of the beat bits, so beat plus par always has even weight.
  assign par_err_c = (^beat) ^ par;

endmodule

// File: rtl/bundle_deser.sv
// Reassembles a serialized pipeline bundle from LSB-first link beats framed by in_sof.
// Optional beat parity checking is enabled by defining BUNDLE_PARITY_EN.
module bundle_deser #(
  parameter int unsigned BUNDLE_W = bundle_pkg::BUNDLE_W,
  parameter int unsigned BEAT_W   = bundle_pkg::BEAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BEAT_W-1:0]   in_beat,
  input  logic                in_sof,
  input  logic                in_valid,
`ifdef BUNDLE_PARITY_EN
  input  logic                in_par,
`endif
  output logic                in_ready,
  output logic [BUNDLE_W-1:0] bundled_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err
);

  import bundle_pkg::*;

  localparam int unsigned N_BEATS  = BUNDLE_W / BEAT_W;
  localparam int unsigned CNT_BITS = cnt_width(N_BEATS);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(N_BEATS - 1);
  localparam logic [CNT_BITS-1:0] ONE_IDX  = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                wr_en;
  logic [CNT_BITS-1:0] wr_idx;
  logic                err_d;
  logic                accept;
  logic                par_err_c;

`ifdef BUNDLE_PARITY_EN
  beat_parity_chk #(
    .BEAT_W (BEAT_W)
  ) u_parity (
    .beat      (in_beat),
    .par       (in_par),
    .par_err_c (par_err_c)
  );
`else
  assign par_err_c = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // Next-state, beat write strobe and error pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (par_err_c) begin
            err_d = 1'b1;
          end else if (in_sof) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (N_BEATS == 1) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              state_d = COLLECT;
              cnt_d   = ONE_IDX;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (accept) begin
          if (par_err_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else if (in_sof) begin
            // Restart framing: the partial bundle is overwritten from beat 0.
            wr_en  = 1'b1;
            wr_idx = '0;
            cnt_d  = ONE_IDX;
            err_d  = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = CNT_BITS'(cnt_q + ONE_IDX);
            end
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_ready  <= (state_d != HOLD);
      out_valid <= (state_d == HOLD);
      frame_err <= err_d;
    end
  end

  // Bundle storage; untouched while holding so the output stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      bundled_out <= '0;
    end else if (wr_en) begin
      bundled_out[wr_idx*BEAT_W +: BEAT_W] <= in_beat;
    end
  end

endmodule

// File: tb/tb_bundle_deser.sv
// Directed self-checking bench for bundle_deser; define BUNDLE_PARITY_EN to
// also exercise the parity abort path.
module tb_bundle_deser;

  localparam int unsigned BW = 144;
  localparam int unsigned BTW = 16;
  localparam int unsigned NB = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [BTW-1:0] in_beat;
  logic          in_sof;
  logic          in_valid;
`ifdef BUNDLE_PARITY_EN
  logic          in_par;
`endif
  logic          in_ready;
  logic [BW-1:0] bundled_out;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bundle_deser #(
    .BUNDLE_W (BW),
    .BEAT_W   (BTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_beat     (in_beat),
    .in_sof      (in_sof),
    .in_valid    (in_valid),
`ifdef BUNDLE_PARITY_EN
    .in_par      (in_par),
`endif
    .in_ready    (in_ready),
    .bundled_out (bundled_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_err   (frame_err)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BTW-1:0] d, input logic sof);
    in_beat  = d;
    in_sof   = sof;
    in_valid = 1'b1;
`ifdef BUNDLE_PARITY_EN
    in_par   = ^d;
`endif
    cyc();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

`ifdef BUNDLE_PARITY_EN
  task automatic send_badpar(input logic [BTW-1:0] d);
    in_beat  = d;
    in_sof   = 1'b0;
    in_valid = 1'b1;
    in_par   = ~(^d);
    cyc();
    in_valid = 1'b0;
  endtask
`endif

  // Expected bundle with beat k = base + k.
  function automatic logic [BW-1:0] mk(input logic [BTW-1:0] base);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*BTW +: BTW] = BTW'(base + BTW'(k));
    return r;
  endfunction

  task automatic send_bundle(input logic [BTW-1:0] base);
    for (int k = 0; k < NB; k++) send(BTW'(base + BTW'(k)), k == 0);
  endtask

  initial begin
    logic [BW-1:0] exp_b;
    reset = 1'b1; in_beat = '0; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef BUNDLE_PARITY_EN
    in_par = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_bundled_out", bundled_out, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    cyc();

    // Basic bundle 0x0001..0x0009 with consumer ready.
    out_ready = 1'b1;
    for (int k = 0; k < NB - 1; k++) send(BTW'(k + 1), k == 0);
    chk("b1_no_valid_before_last", out_valid, 0);
    send(16'h0009, 1'b0);
    chk("b1_out_valid", out_valid, 1);
    chk("b1_in_ready_low", in_ready, 0);
    chk("b1_low_slice", bundled_out[15:0], 16'h0001);
    chk("b1_high_slice", bundled_out[143:128], 16'h0009);
    chk("b1_bundle", bundled_out, mk(16'h0001));
    chk("b1_no_err", frame_err, 0);
    cyc();
    chk("b1_released", out_valid, 0);
    chk("b1_ready_again", in_ready, 1);

    // Back-pressure: held for 5 cycles, input offered but refused.
    out_ready = 1'b0;
    send_bundle(16'h1100);
    exp_b = mk(16'h1100);
    in_beat = 16'hdead; in_sof = 1'b1; in_valid = 1'b1;
`ifdef BUNDLE_PARITY_EN
    in_par = ^in_beat;
`endif
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", bundled_out, exp_b);
      chk("hold_no_err", frame_err, 0);
      cyc();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);
    chk("hold_data_kept", bundled_out, exp_b);

    // Re-sync: in_sof again at beat 4, then 9 fresh beats.
    for (int k = 0; k < 4; k++) send(BTW'(16'h2000 + k), k == 0);
    chk("resync_no_err_yet", frame_err, 0);
    send(16'h3000, 1'b1);
    chk("resync_err_pulse", frame_err, 1);
    send(16'h3001, 1'b0);
    chk("resync_err_one_cycle", frame_err, 0);
    for (int k = 2; k < NB; k++) send(BTW'(16'h3000 + k), 1'b0);
    chk("resync_valid", out_valid, 1);
    chk("resync_bundle", bundled_out, mk(16'h3000));
    cyc();
    chk("resync_released", out_valid, 0);

    // Stray beat while idle is dropped with a pulse.
    send(16'hbeef, 1'b0);
    chk("idle_stray_err", frame_err, 1);
    chk("idle_stray_ready", in_ready, 1);
    chk("idle_stray_no_valid", out_valid, 0);
    chk("idle_stray_dropped", bundled_out, mk(16'h3000));
    cyc();
    chk("idle_stray_err_clear", frame_err, 0);

    // Reset mid-bundle, with a competing sof beat and out_ready.
    for (int k = 0; k < 6; k++) send(BTW'(16'h5000 + k), k == 0);
    reset = 1'b1; in_beat = 16'h5555; in_sof = 1'b1; in_valid = 1'b1;
    cyc();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_err", frame_err, 0);
    chk("rst_mid_data", bundled_out, 0);
    chk("rst_mid_ready", in_ready, 1);
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    cyc();
    chk("rst_mid_no_valid_after", out_valid, 0);
    send_bundle(16'h6000);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_bundle", bundled_out, mk(16'h6000));
    chk("post_rst_no_err", frame_err, 0);
    cyc();
    chk("post_rst_released", out_valid, 0);

`ifdef BUNDLE_PARITY_EN
    // Parity error on beat 3 aborts the bundle.
    for (int k = 0; k < 3; k++) send(BTW'(16'h7000 + k), k == 0);
    send_badpar(16'h7003);
    chk("par_err_pulse", frame_err, 1);
    chk("par_no_valid", out_valid, 0);
    for (int k = 4; k < NB; k++) send(BTW'(16'h7000 + k), 1'b0);
    chk("par_aborted_no_valid", out_valid, 0);
    cyc();
    chk("par_err_clear", frame_err, 0);
    send_bundle(16'h7100);
    chk("par_next_valid", out_valid, 1);
    chk("par_next_bundle", bundled_out, mk(16'h7100));
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
